sum_capture_fifo: RTL and testbench
===================================

// Module: sum_capture_fifo
// PURPOSE
//   Downstream stage of the top-level adder: captures the 9-bit result {carry, ui_in+uio_in}
//   into a small FIFO on a strobe pin, releases entries on a pop strobe, and flags overflow.
//   Strobe pins arrive asynchronously from the board and are synchronized and edge-detected
//   here; stored results drive the output pins of the top-level wrapper.
// PARAMETERS
//   WIDTH       8  result width excluding carry; stored entry is WIDTH+1 bits {carry,sum}
//   DEPTH       4  FIFO entries; power of 2, >= 2
//   SYNC_STAGES 2  synchronizer flops on push_in/pop_in; >= 2
// PORTS
//   clk        in   1            system clock
//   rst_n      in   1            asynchronous reset, active low
//   ena        in   1            stage enable; low freezes FIFO state (synchronizers keep running)
//   sum_in     in   WIDTH        adder result, sampled unsynchronized on the write edge
//   carry_in   in   1            adder carry-out (bit WIDTH of the full sum)
//   push_in    in   1            raw push strobe; rising edge requests one capture
//   pop_in     in   1            raw pop strobe; rising edge releases the head entry
//   clr        in   1            synchronous clear of FIFO and sticky flags
//   data_out   out  WIDTH        head entry sum; 0 when empty (registered)
//   carry_out  out  1            head entry carry; 0 when empty (registered)
//   count      out  $clog2(DEPTH)+1  number of valid entries
//   empty      out  1            count == 0
//   full       out  1            count == DEPTH
//   overflow   out  1            sticky: push dropped because FIFO full
//   underflow  out  1            sticky: pop ignored because FIFO empty
// BEHAVIOUR
//   - Reset (rst_n=0, async): pointers, count, data_out, carry_out, overflow, underflow = 0;
//     empty=1, full=0; all synchronizer and edge-detect flops = 0. Storage array not reset.
//   - Sync/edge: each strobe passes SYNC_STAGES flops then one history flop; push_evt/pop_evt =
//     last_sync & ~history. Strobe first sampled high at edge N -> event acts at edge N+SYNC_STAGES.
//     One event per rising edge, regardless of high-pulse length; strobe must stay high and low
//     >= 1 cycle each.
//   - Write: on push_evt & ena & ~full, mem[wr_ptr] <= {carry_in,sum_in}; wr_ptr++ (wraps mod DEPTH).
//     sum_in/carry_in must be stable from strobe rise until the write edge.
//   - Read: on pop_evt & ena & ~empty, rd_ptr++ (wraps mod DEPTH).
//   - count: +1 on write only, -1 on read only, unchanged on both.
//   - Simultaneous push+pop:
//     - not empty/full: both occur.
//     - full: pop then push both occur; no overflow.
//     - empty: push accepted, pop ignored, underflow set; no bypass.
//   - Full push: entry dropped, overflow <= 1. Empty pop: underflow <= 1. Flags held until clr/reset.
//   - data_out/carry_out registered: updated one edge after any write/read/clr to the new head
//     (mem[rd_ptr]), or 0 if the resulting FIFO is empty.
//   - clr (when ena=1): highest priority; same-cycle events discarded; pointers, count, flags,
//     data_out, carry_out -> 0. clr with ena=0 ignored.
//   - ena=0: no pointer, count, flag or storage change. Events detected while ena=0 are lost, not queued.
//   - Reset mid-operation: all contents lost. A strobe held high through reset release produces
//     an event (history flop starts at 0).
// TESTING
//   1 reset: rst_n=0 mid-run with count=3 -> count=0, empty=1, data_out=0, flags=0, no clk needed.
//   2 latency: sum_in=8'h3C, carry=0, push rises at edge N -> count=1 after edge N+2;
//     data_out=8'h3C after edge N+3.
//   3 order/wrap: push 8'h01..8'h06 with 3 interleaved pops -> pops return 01,02,03 in order;
//     later 04,05,06; wr_ptr wraps past DEPTH-1; count correct throughout.
//   4 full: push 5 values (8'hA0..8'hA4) with DEPTH=4 -> full=1, overflow=1; pops return A0..A3.
//   5 simultaneous: full FIFO, push 8'hFF and pop on same edge -> count stays 4, no overflow,
//     8'hFF becomes last entry. Empty FIFO, both -> count=1, underflow=1.
//   6 carry/clr/ena: 8'hF0+8'h20 = {carry=1, 8'h10} captured; ena=0 push ignored; clr -> all 0.

Source files
------------

// File: rtl/sum_capture_fifo_if.sv
// sum_capture_fifo_if: strobe, data and status bundle between the adder wrapper and the capture FIFO.
interface sum_capture_fifo_if #(parameter int WIDTH = 8, parameter int DEPTH = 4);
  logic ena, carry_in, push_in, pop_in, clr;
  logic [WIDTH-1:0] sum_in, data_out;
  logic carry_out, empty, full, overflow, underflow;
  logic [$clog2(DEPTH):0] count;
  modport slave(input ena, sum_in, carry_in, push_in, pop_in, clr,
                output data_out, carry_out, count, empty, full, overflow, underflow);
  modport master(output ena, sum_in, carry_in, push_in, pop_in, clr,
                 input data_out, carry_out, count, empty, full, overflow, underflow);
endinterface

// File: rtl/sum_capture_fifo.sv
// sum_capture_fifo: captures {carry,sum} on synchronized push strobes, releases on pop strobes, flags misuse.
module sum_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  sum_capture_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [SYNC_STAGES-1:0] push_sync_q, pop_sync_q;
  logic push_hist_q, pop_hist_q;
  logic [WIDTH:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic [WIDTH:0] head_q, head_d;
  logic push_evt, pop_evt, do_clr, do_wr, do_rd, empty, full;
  always_comb begin
    empty = count_q == '0;
    full = count_q == (AW+1)'(DEPTH);
    push_evt = push_sync_q[SYNC_STAGES-1] & ~push_hist_q;
    pop_evt = pop_sync_q[SYNC_STAGES-1] & ~pop_hist_q;
    do_clr = bus.ena & bus.clr;
    do_rd = bus.ena & ~bus.clr & pop_evt & ~empty;
    // a pop in the same cycle frees the slot a full-FIFO push needs
    do_wr = bus.ena & ~bus.clr & push_evt & (~full | pop_evt);
    wr_ptr_d = do_clr ? '0 : wr_ptr_q + AW'(do_wr);
    rd_ptr_d = do_clr ? '0 : rd_ptr_q + AW'(do_rd);
    count_d = do_clr ? '0 : count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    ovf_d = do_clr ? 1'b0 : ovf_q | (bus.ena & push_evt & full & ~pop_evt);
    udf_d = do_clr ? 1'b0 : udf_q | (bus.ena & pop_evt & empty);
    // head lags the pointer/count update by one edge
    head_d = (do_clr | empty) ? '0 : mem[rd_ptr_q];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_sync_q <= '0;
      pop_sync_q <= '0;
      push_hist_q <= 1'b0;
      pop_hist_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      head_q <= '0;
    end else begin
      push_sync_q <= {push_sync_q[SYNC_STAGES-2:0], bus.push_in};
      pop_sync_q <= {pop_sync_q[SYNC_STAGES-2:0], bus.pop_in};
      push_hist_q <= push_sync_q[SYNC_STAGES-1];
      pop_hist_q <= pop_sync_q[SYNC_STAGES-1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      head_q <= head_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= {bus.carry_in, bus.sum_in};
  end
  assign bus.data_out = head_q[WIDTH-1:0];
  assign bus.carry_out = head_q[WIDTH];
  assign bus.count = count_q;
  assign bus.empty = empty;
  assign bus.full = full;
  assign bus.overflow = ovf_q;
  assign bus.underflow = udf_q;
endmodule

// File: tb/tb_sum_capture_fifo.sv
// tb_sum_capture_fifo: queue-model scoreboard checked every cycle plus hand-computed directed expectations.
module tb_sum_capture_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  sum_capture_fifo_if #(.WIDTH(8), .DEPTH(4)) bus();
  sum_capture_fifo #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  logic [8:0] q[$];
  logic m_ovf = 1'b0, m_udf = 1'b0;
  logic [8:0] m_head = '0;
  logic [2:0] ph = '0, pp = '0;
  bit pe, qe, rd, wr;
  logic [8:0] wide_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a strobe sample taken k edges ago is ph[k-1]; a rise seen two edges back acts now
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_head = '0;
      ph = '0;
      pp = '0;
    end else begin
      pe = ph[1] & ~ph[2];
      qe = pp[1] & ~pp[2];
      m_head = ((bus.ena && bus.clr) || q.size() == 0) ? 9'h0 : q[0];
      if (bus.ena && bus.clr) begin
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end else if (bus.ena) begin
        rd = qe && q.size() > 0;
        wr = pe && (q.size() < 4 || rd);
        if (qe && q.size() == 0) m_udf = 1'b1;
        if (pe && !wr) m_ovf = 1'b1;
        if (rd) void'(q.pop_front());
        if (wr) q.push_back({bus.carry_in, bus.sum_in});
      end
      ph = {ph[1:0], bus.push_in};
      pp = {pp[1:0], bus.pop_in};
    end
  end

  initial forever begin
    @(negedge clk);
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("flags", {bus.empty, bus.full, bus.overflow, bus.underflow},
        {q.size() == 0, q.size() == 4, m_ovf, m_udf});
    chk("head", {bus.carry_out, bus.data_out}, 32'(m_head));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [7:0] v, input logic c);
    bus.sum_in = v;
    bus.carry_in = c;
    bus.push_in = 1'b1;
    tick(1);
    bus.push_in = 1'b0;
    tick(3);
  endtask
  task automatic pop();
    bus.pop_in = 1'b1;
    tick(1);
    bus.pop_in = 1'b0;
    tick(3);
  endtask
  task automatic both(input logic [7:0] v);
    bus.sum_in = v;
    bus.carry_in = 1'b0;
    bus.push_in = 1'b1;
    bus.pop_in = 1'b1;
    tick(1);
    bus.push_in = 1'b0;
    bus.pop_in = 1'b0;
    tick(3);
  endtask
  task automatic clear();
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    tick(1);
  endtask

  initial begin
    bus.ena = 1'b1;
    bus.sum_in = '0;
    bus.carry_in = 1'b0;
    bus.push_in = 1'b0;
    bus.pop_in = 1'b0;
    bus.clr = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    // latency: rise sampled at edge N, count at N+2, head at N+3
    bus.sum_in = 8'h3C;
    bus.push_in = 1'b1;
    tick(1);
    bus.push_in = 1'b0;
    tick(1);
    chk("lat_count_n1", 32'(bus.count), 0);
    tick(1);
    chk("lat_count_n2", 32'(bus.count), 1);
    chk("lat_head_n2", 32'(bus.data_out), 0);
    tick(1);
    chk("lat_head_n3", 32'(bus.data_out), 32'h3C);
    pop();
    chk("lat_drained", 32'(bus.empty), 1);
    // order and pointer wrap
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    chk("ord_head01", 32'(bus.data_out), 32'h01);
    pop();
    chk("ord_head02", 32'(bus.data_out), 32'h02);
    push(8'h03, 1'b0);
    push(8'h04, 1'b0);
    pop();
    chk("ord_head03", 32'(bus.data_out), 32'h03);
    push(8'h05, 1'b0);
    pop();
    push(8'h06, 1'b0);
    chk("ord_count3", 32'(bus.count), 3);
    chk("ord_head04", 32'(bus.data_out), 32'h04);
    pop();
    chk("ord_head05", 32'(bus.data_out), 32'h05);
    pop();
    chk("ord_head06", 32'(bus.data_out), 32'h06);
    pop();
    chk("ord_empty", 32'(bus.empty), 1);
    // asynchronous reset with three entries held
    push(8'h07, 1'b0);
    push(8'h08, 1'b0);
    push(8'h09, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_empty", 32'(bus.empty), 1);
    chk("arst_head", 32'(bus.data_out), 0);
    chk("arst_flags", {bus.overflow, bus.underflow}, 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    // full, simultaneous push+pop on full, then overflow
    push(8'hA0, 1'b0);
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    push(8'hA3, 1'b0);
    chk("full_flag", 32'(bus.full), 1);
    chk("full_no_ovf", 32'(bus.overflow), 0);
    chk("full_headA0", 32'(bus.data_out), 32'hA0);
    both(8'hFF);
    chk("sim_full_count", 32'(bus.count), 4);
    chk("sim_full_no_ovf", 32'(bus.overflow), 0);
    chk("sim_full_headA1", 32'(bus.data_out), 32'hA1);
    push(8'hA4, 1'b0);
    chk("ovf_set", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 4);
    pop();
    chk("drain_A2", 32'(bus.data_out), 32'hA2);
    pop();
    chk("drain_A3", 32'(bus.data_out), 32'hA3);
    pop();
    chk("drain_FF", 32'(bus.data_out), 32'hFF);
    pop();
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_no_udf", 32'(bus.underflow), 0);
    // simultaneous on empty: push wins, pop flags underflow
    both(8'h55);
    chk("sim_empty_count", 32'(bus.count), 1);
    chk("sim_empty_udf", 32'(bus.underflow), 1);
    chk("sim_empty_head", 32'(bus.data_out), 32'h55);
    // clr, carry capture, ena gating
    clear();
    chk("clr_count", 32'(bus.count), 0);
    chk("clr_flags", {bus.overflow, bus.underflow}, 0);
    wide_sum = 9'(8'hF0) + 9'(8'h20);
    push(wide_sum[7:0], wide_sum[8]);
    chk("carry_out", 32'(bus.carry_out), 1);
    chk("carry_sum", 32'(bus.data_out), 32'h10);
    bus.ena = 1'b0;
    push(8'h77, 1'b0);
    chk("ena0_push", 32'(bus.count), 1);
    clear();
    chk("ena0_clr", 32'(bus.count), 1);
    bus.ena = 1'b1;
    tick(1);
    clear();
    chk("final_count", 32'(bus.count), 0);
    chk("final_carry", 32'(bus.carry_out), 0);
    chk("final_empty", 32'(bus.empty), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
